alu_adder: RTL and testbench

- Registered add/subtract unit for the ALU datapath.
- Takes two operands and the 4-bit ALU op select ({funct7[5], funct3} encoding).
- Produces the two's-complement sum or difference plus status flags, one clock after the inputs are accepted.
- Sits beside the logic/shift units inside the ALU; its result also feeds compare/branch logic.

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu_adder_core.sv | 32 +++
 rtl/alu_adder.sv | 79 +++++++
 tb/tb_alu_adder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes and default operand width
package alu_pkg;

  localparam int          ALU_OPERAND_LENGTH = 32;
  localparam logic [3:0]  ALU_OP_ADD         = 4'b0000;
  localparam logic [3:0]  ALU_OP_SUB         = 4'b1000;
  localparam int          ALU_OP_SUB_BIT     = 3;

endpackage

// File: rtl/alu_adder_core.sv
// rtl/alu_adder_core.sv - combinational add/subtract with carry, overflow, zero, negative
module alu_adder_core
  import alu_pkg::*;
#(
  parameter int OPERAND_LENGTH = ALU_OPERAND_LENGTH
) (
  input  logic [OPERAND_LENGTH-1:0] opd1,
  input  logic [OPERAND_LENGTH-1:0] opd2,
  input  logic                      sub,
  output logic [OPERAND_LENGTH-1:0] sum,
  output logic                      carry_out,
  output logic                      overflow,
  output logic                      zero,
  output logic                      negative
);

  localparam int N = OPERAND_LENGTH;

  logic [N-1:0] w_opd2_x;
  logic [N:0]   w_sum_full;

  // Subtract reuses the adder: invert the subtrahend and feed sub in as carry-in.
  assign w_opd2_x   = opd2 ^ {N{sub}};
  assign w_sum_full = {1'b0, opd1} + {1'b0, w_opd2_x} + {{N{1'b0}}, sub};

  assign sum       = w_sum_full[N-1:0];
  assign carry_out = w_sum_full[N];
  assign overflow  = (opd1[N-1] == w_opd2_x[N-1]) && (w_sum_full[N-1] != opd1[N-1]);
  assign zero      = (w_sum_full[N-1:0] == '0);
  assign negative  = w_sum_full[N-1];

endmodule

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - registered add/subtract unit, one cycle latency
module alu_adder
  import alu_pkg::*;
#(
  parameter int OPERAND_LENGTH = ALU_OPERAND_LENGTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [OPERAND_LENGTH-1:0] opd1,
  input  logic [OPERAND_LENGTH-1:0] opd2,
  input  logic [3:0]                alu_op_select,
  output logic                      out_valid,
  output logic [OPERAND_LENGTH-1:0] adder_result,
  output logic                      carry_out,
  output logic                      overflow,
  output logic                      zero,
  output logic                      negative
);

  logic                      w_sub;
  logic [OPERAND_LENGTH-1:0] w_sum;
  logic                      w_carry;
  logic                      w_overflow;
  logic                      w_zero;
  logic                      w_negative;

  logic                      r_valid;
  logic [OPERAND_LENGTH-1:0] r_result;
  logic                      r_carry;
  logic                      r_overflow;
  logic                      r_zero;
  logic                      r_negative;

  // Only the subtract bit matters; masking keeps the other op bits out of the decode.
  assign w_sub = ((alu_op_select & ALU_OP_SUB) != 4'b0000);

  alu_adder_core #(
    .OPERAND_LENGTH (OPERAND_LENGTH)
  ) u_core (
    .opd1      (opd1),
    .opd2      (opd2),
    .sub       (w_sub),
    .sum       (w_sum),
    .carry_out (w_carry),
    .overflow  (w_overflow),
    .zero      (w_zero),
    .negative  (w_negative)
  );

  // Result and flags hold across idle cycles; only out_valid tracks in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_sum;
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
        r_zero     <= w_zero;
        r_negative <= w_negative;
      end
    end
  end

  assign out_valid    = r_valid;
  assign adder_result = r_result;
  assign carry_out    = r_carry;
  assign overflow     = r_overflow;
  assign zero         = r_zero;
  assign negative     = r_negative;

endmodule

// File: tb/tb_alu_adder.sv
// tb/tb_alu_adder.sv - directed self-checking bench for alu_adder
module tb_alu_adder;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] opd1 = '0;
  logic [31:0] opd2 = '0;
  logic [3:0]  alu_op_select = 4'b0000;
  logic        out_valid;
  logic [31:0] adder_result;
  logic        carry_out;
  logic        overflow;
  logic        zero;
  logic        negative;

  int checks = 0;
  int errors = 0;

  // flg = {carry, overflow, zero, negative}
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  alu_adder #(.OPERAND_LENGTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .opd1          (opd1),
    .opd2          (opd2),
    .alu_op_select (alu_op_select),
    .out_valid     (out_valid),
    .adder_result  (adder_result),
    .carry_out     (carry_out),
    .overflow      (overflow),
    .zero          (zero),
    .negative      (negative)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op_select = op;
    opd1          = a;
    opd2          = b;
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    opd1     = $urandom;
    opd2     = $urandom;
    alu_op_select = 4'($urandom_range(0, 15));
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== 37'd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b res=%h flags=%b%b%b%b, want all zero",
               out_valid, adder_result, carry_out, overflow, zero, negative);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(ALU_OP_ADD, 32'd0, 32'd1);
    checks++;
    if ({out_valid, adder_result} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL reset_release: got valid=%b res=%h, want valid=1 res=00000001",
               out_valid, adder_result);
    end
  endtask

  task automatic test_add;
    vec_t v[3];
    v = '{'{ALU_OP_ADD, 32'd1,        32'd5,        32'd6,        4'b0000},
          '{ALU_OP_ADD, 32'd0,        32'd0,        32'd0,        4'b0010},
          '{ALU_OP_ADD, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 4'b1001}};
    for (int i = 0; i < 3; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== {1'b1, v[i].res, v[i].flg}) begin
        errors++;
        $display("FAIL add[%0d]: got valid=%b res=%h cvzn=%b%b%b%b, want valid=1 res=%h cvzn=%b",
                 i, out_valid, adder_result, carry_out, overflow, zero, negative, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_sub;
    vec_t v[5];
    v = '{'{ALU_OP_SUB, 32'd6,        32'd3,        32'd3,        4'b1000},
          '{ALU_OP_SUB, 32'd6,        32'd4,        32'd2,        4'b1000},
          '{ALU_OP_SUB, 32'd6,        32'd7,        32'hFFFFFFFF, 4'b0001},
          '{ALU_OP_SUB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        4'b1000},
          '{ALU_OP_SUB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001}};
    for (int i = 0; i < 5; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== {1'b1, v[i].res, v[i].flg}) begin
        errors++;
        $display("FAIL sub[%0d]: got valid=%b res=%h cvzn=%b%b%b%b, want valid=1 res=%h cvzn=%b",
                 i, out_valid, adder_result, carry_out, overflow, zero, negative, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_overflow;
    vec_t v[3];
    v = '{'{ALU_OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0101},
          '{ALU_OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b1100},
          '{ALU_OP_SUB, 32'd5,        32'd5, 32'd0,        4'b1010}};
    for (int i = 0; i < 3; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== {1'b1, v[i].res, v[i].flg}) begin
        errors++;
        $display("FAIL ovf[%0d]: got valid=%b res=%h cvzn=%b%b%b%b, want valid=1 res=%h cvzn=%b",
                 i, out_valid, adder_result, carry_out, overflow, zero, negative, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_op_decode;
    vec_t v[2];
    v = '{'{4'b1010, 32'd6, 32'd7, 32'hFFFFFFFF, 4'b0001},
          '{4'b0111, 32'd6, 32'd7, 32'd13,       4'b0000}};
    for (int i = 0; i < 2; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== {1'b1, v[i].res, v[i].flg}) begin
        errors++;
        $display("FAIL opdec[%0d]: got valid=%b res=%h cvzn=%b%b%b%b, want valid=1 res=%h cvzn=%b",
                 i, out_valid, adder_result, carry_out, overflow, zero, negative, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[4];
    v = '{'{ALU_OP_ADD, 32'd100,      32'd23,       32'd123,      4'b0000},
          '{ALU_OP_SUB, 32'd10,       32'd10,       32'd0,        4'b1010},
          '{ALU_OP_ADD, 32'h80000000, 32'h80000000, 32'd0,        4'b1110},
          '{ALU_OP_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b0001}};
    for (int i = 0; i < 4; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== {1'b1, v[i].res, v[i].flg}) begin
        errors++;
        $display("FAIL b2b[%0d]: got valid=%b res=%h cvzn=%b%b%b%b, want valid=1 res=%h cvzn=%b",
                 i, out_valid, adder_result, carry_out, overflow, zero, negative, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_idle_hold;
    @(negedge clk);
    in_valid      = 1'b0;
    opd1          = 32'd7;
    opd2          = 32'd8;
    alu_op_select = ALU_OP_ADD;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== {1'b0, 32'hFFFFFFFF, 4'b0001}) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got valid=%b res=%h cvzn=%b%b%b%b, want valid=0 res=ffffffff cvzn=0001",
                 i, out_valid, adder_result, carry_out, overflow, zero, negative);
      end
    end
  endtask

  task automatic test_reset_mid_stream;
    drive(ALU_OP_ADD, 32'h7FFFFFFF, 32'd1);
    @(negedge clk);
    rst_n         = 1'b0;
    in_valid      = 1'b1;
    opd1          = 32'd3;
    opd2          = 32'd4;
    alu_op_select = ALU_OP_ADD;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, adder_result, carry_out, overflow, zero, negative} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b res=%h cvzn=%b%b%b%b, want all zero",
               out_valid, adder_result, carry_out, overflow, zero, negative);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_op_decode();
    test_back_to_back();
    test_idle_hold();
    test_reset_mid_stream();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
